mqs_axi4_rd_arbiter: RTL and testbench

Shares one AXI4 slave read port (AR + R) between `NUM_MST` masters. It sits upstream of the AXI4 register-slice pipeline on the slave path. It grants one master at a time with round-robin priority and holds the grant through the full read burst. Only one read transaction is outstanding at a time, so R beats route back to the owning master without ID remapping.

---
 rtl/mqs_axi_arb_pkg.sv | 14 +
 rtl/mqs_rr_arbiter.sv | 56 +++++
 rtl/mqs_axi4_rd_arbiter.sv | 115 +++++++++++
 tb/tb_mqs_axi4_rd_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mqs_axi_arb_pkg.sv
// Shared types and constants for the AXI4 read-port arbiter.
// Optional QoS-based selection is enabled with MQS_AXI_RD_ARB_QOS_EN.
package mqs_axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam int unsigned QOS_W   = 4;
  localparam int unsigned MAX_MST = 8;

endpackage

// File: rtl/mqs_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
// With MQS_AXI_RD_ARB_QOS_EN defined, only the highest-QoS requesters compete.
module mqs_rr_arbiter
  import mqs_axi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [IDX_W-1:0]         ptr_i,
`ifdef MQS_AXI_RD_ARB_QOS_EN
  input  logic [NUM_REQ*QOS_W-1:0] qos_i,
`endif
  output logic [NUM_REQ-1:0]       gnt_oh_o,
  output logic [IDX_W-1:0]         gnt_idx_o
);

  logic [NUM_REQ-1:0] cand;
  logic               found;
  int unsigned        j;

`ifdef MQS_AXI_RD_ARB_QOS_EN
  logic [QOS_W-1:0] max_qos;

  always_comb begin
    max_qos = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && (qos_i[i*QOS_W +: QOS_W] > max_qos)) begin
        max_qos = qos_i[i*QOS_W +: QOS_W];
      end
    end
    cand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand[i] = req_i[i] && (qos_i[i*QOS_W +: QOS_W] == max_qos);
    end
  end
`else
  assign cand = req_i;
`endif

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr_i) + k) % NUM_REQ;
      if (!found && cand[j]) begin
        found       = 1'b1;
        gnt_oh_o[j] = 1'b1;
        gnt_idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mqs_axi4_rd_arbiter.sv
// Shares one AXI4 read port (AR + R) between NUM_MST masters, one burst at a time.
// Define MQS_AXI_RD_ARB_QOS_EN to let the highest ARQOS win ahead of round robin.
module mqs_axi4_rd_arbiter
  import mqs_axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MST = 2,
  parameter int unsigned AR_W    = 96,
  parameter int unsigned R_W     = 75
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [NUM_MST-1:0]         m_ARVALID,
  output logic [NUM_MST-1:0]         m_ARREADY,
  input  logic [NUM_MST*AR_W-1:0]    m_ARPAYLOAD,
  input  logic [NUM_MST*QOS_W-1:0]   m_ARQOS,
  output logic [NUM_MST-1:0]         m_RVALID,
  input  logic [NUM_MST-1:0]         m_RREADY,
  output logic [R_W-1:0]             m_RPAYLOAD,
  output logic                       m_RLAST,
  output logic                       s_ARVALID,
  input  logic                       s_ARREADY,
  output logic [AR_W-1:0]            s_ARPAYLOAD,
  output logic [QOS_W-1:0]           s_ARQOS,
  input  logic                       s_RVALID,
  output logic                       s_RREADY,
  input  logic [R_W-1:0]             s_RPAYLOAD,
  input  logic                       s_RLAST,
  output logic [$clog2(NUM_MST)-1:0] grant_idx,
  output logic                       busy
);

  localparam int unsigned IDX_W = $clog2(NUM_MST);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [NUM_MST-1:0] gnt_oh_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [NUM_MST-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;

  mqs_rr_arbiter #(
    .NUM_REQ (NUM_MST),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i     (m_ARVALID),
    .ptr_i     (ptr_q),
`ifdef MQS_AXI_RD_ARB_QOS_EN
    .qos_i     (m_ARQOS),
`endif
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx)
  );

  assign ptr_d = (grant_q == IDX_W'(NUM_MST - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gnt_oh_q <= '0;
      ptr_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (|m_ARVALID) begin
          state_q  <= ADDR;
          grant_q  <= arb_idx;
          gnt_oh_q <= arb_oh;
        end
        ADDR: if (s_ARVALID && s_ARREADY) state_q <= DATA;
        DATA: if (s_RVALID && s_RREADY && s_RLAST) begin
          state_q <= IDLE;
          ptr_q   <= ptr_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshakes are steered by the registered one-hot owner; state gates which channel is open.
  always_comb begin
    m_ARREADY = '0;
    m_RVALID  = '0;
    s_ARVALID = 1'b0;
    s_RREADY  = 1'b0;
    unique case (state_q)
      ADDR: begin
        s_ARVALID = |(m_ARVALID & gnt_oh_q);
        m_ARREADY = gnt_oh_q & {NUM_MST{s_ARREADY}};
      end
      DATA: begin
        m_RVALID = gnt_oh_q & {NUM_MST{s_RVALID}};
        s_RREADY = |(m_RREADY & gnt_oh_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    s_ARPAYLOAD = '0;
    s_ARQOS     = '0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      if (grant_q == IDX_W'(i)) begin
        s_ARPAYLOAD = m_ARPAYLOAD[i*AR_W +: AR_W];
        s_ARQOS     = m_ARQOS[i*QOS_W +: QOS_W];
      end
    end
  end

  assign m_RPAYLOAD = s_RPAYLOAD;
  assign m_RLAST    = s_RLAST;
  assign grant_idx  = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mqs_axi4_rd_arbiter.sv
// Directed self-checking bench for mqs_axi4_rd_arbiter with two masters.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mqs_axi4_rd_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 96;
  localparam int unsigned RW = 75;

  logic            ACLK = 1'b0;
  logic            ARESETn;
  logic [NM-1:0]   m_ARVALID, m_ARREADY, m_RVALID, m_RREADY;
  logic [NM*AW-1:0] m_ARPAYLOAD;
  logic [NM*4-1:0] m_ARQOS;
  logic [RW-1:0]   m_RPAYLOAD, s_RPAYLOAD;
  logic            m_RLAST, s_ARVALID, s_ARREADY, s_RVALID, s_RREADY, s_RLAST, busy;
  logic [AW-1:0]   s_ARPAYLOAD;
  logic [3:0]      s_ARQOS;
  logic [0:0]      grant_idx;

  localparam logic [AW-1:0] P0 = 96'h0000_0A00_0000_1000_0003_0000;
  localparam logic [AW-1:0] P1 = 96'h0000_0B11_0000_2000_0000_0000;
  localparam logic [RW-1:0] RB = 75'h5_0000_0000_0000_AA00;

  mqs_axi4_rd_arbiter #(.NUM_MST(NM), .AR_W(AW), .R_W(RW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARPAYLOAD(m_ARPAYLOAD),
    .m_ARQOS(m_ARQOS), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
    .m_RPAYLOAD(m_RPAYLOAD), .m_RLAST(m_RLAST),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARPAYLOAD(s_ARPAYLOAD),
    .s_ARQOS(s_ARQOS), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .s_RPAYLOAD(s_RPAYLOAD), .s_RLAST(s_RLAST),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    ARESETn   = 1'b0;
    m_ARVALID = '0;
    m_RREADY  = '0;
    m_ARQOS   = '0;
    s_ARREADY = 1'b1;
    s_RVALID  = 1'b0;
    s_RLAST   = 1'b0;
    s_RPAYLOAD = '0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic pat [4];
    int unsigned idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    m_ARPAYLOAD = {P1, P0};

    // Reset values
    do_reset();
    ARESETn = 1'b0;
    #1;
    check("rst_arready", m_ARREADY, 2'b00);
    check("rst_rvalid",  m_RVALID,  2'b00);
    check("rst_arvalid", s_ARVALID, 1'b0);
    check("rst_rready",  s_RREADY,  1'b0);
    check("rst_grant",   grant_idx, 1'b0);
    check("rst_busy",    busy,      1'b0);

    // Master 0 alone, 4-beat burst
    do_reset();
    m_ARVALID = 2'b01;
    #1;
    check("t1_arv_pre", s_ARVALID, 1'b0);
    @(negedge ACLK); #1;
    check("t1_arv",     s_ARVALID,   1'b1);
    check("t1_grant",   grant_idx,   1'b0);
    check("t1_payload", s_ARPAYLOAD, P0);
    check("t1_arready", m_ARREADY,   2'b01);
    check("t1_busy",    busy,        1'b1);
    @(negedge ACLK);
    m_ARVALID = 2'b00;
    m_RREADY  = 2'b11;
    for (int b = 0; b < 4; b++) begin
      s_RVALID   = 1'b1;
      s_RPAYLOAD = RB + RW'(b);
      s_RLAST    = (b == 3);
      #1;
      check("t1_rvalid", m_RVALID,   2'b01);
      check("t1_rready", s_RREADY,   1'b1);
      check("t1_rdata",  m_RPAYLOAD, RB + RW'(b));
      check("t1_rlast",  m_RLAST,    (b == 3));
      @(negedge ACLK);
    end
    s_RVALID = 1'b0;
    s_RLAST  = 1'b0;
    #1;
    check("t1_idle", busy, 1'b0);

    // Both masters request: 0 then 1, then 0 again
    do_reset();
    m_ARVALID = 2'b11;
    m_RREADY  = 2'b11;
    @(negedge ACLK); #1;
    check("t2_g0",       grant_idx,   1'b0);
    check("t2_arready0", m_ARREADY,   2'b01);
    check("t2_pay0",     s_ARPAYLOAD, P0);
    @(negedge ACLK);
    m_ARVALID = 2'b10;
    s_RVALID  = 1'b1;
    s_RLAST   = 1'b1;
    #1;
    check("t2_rvalid0", m_RVALID, 2'b01);
    @(negedge ACLK);
    s_RVALID = 1'b0;
    s_RLAST  = 1'b0;
    #1;
    check("t2_gap_busy", busy,      1'b0);
    check("t2_gap_arv",  s_ARVALID, 1'b0);
    @(negedge ACLK); #1;
    check("t2_g1",       grant_idx,   1'b1);
    check("t2_arready1", m_ARREADY,   2'b10);
    check("t2_pay1",     s_ARPAYLOAD, P1);
    @(negedge ACLK);
    m_ARVALID = 2'b11;
    s_RVALID  = 1'b1;
    s_RLAST   = 1'b1;
    #1;
    check("t2_rvalid1", m_RVALID, 2'b10);
    @(negedge ACLK);
    s_RVALID = 1'b0;
    s_RLAST  = 1'b0;
    @(negedge ACLK); #1;
    check("t2_g0_again", grant_idx, 1'b0);

    // Slave AR stall with a competing master
    do_reset();
    s_ARREADY = 1'b0;
    m_ARVALID = 2'b01;
    @(negedge ACLK);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) m_ARVALID = 2'b11;
      #1;
      check("t3_arready", m_ARREADY,   2'b00);
      check("t3_arvalid", s_ARVALID,   1'b1);
      check("t3_payload", s_ARPAYLOAD, P0);
      check("t3_grant",   grant_idx,   1'b0);
      @(negedge ACLK);
    end
    s_ARREADY = 1'b1;
    #1;
    check("t3_arready_go", m_ARREADY, 2'b01);
    @(negedge ACLK);
    m_ARVALID = 2'b10;
    #1;
    check("t3_data_grant", grant_idx, 1'b0);
    check("t3_data_busy",  busy,      1'b1);

    // R backpressure from master 1: ready pattern 1,0,0,1 over a 2-beat burst
    do_reset();
    m_ARVALID = 2'b10;
    m_RREADY  = 2'b01;
    @(negedge ACLK); #1;
    check("t4_grant", grant_idx, 1'b1);
    @(negedge ACLK);
    m_ARVALID = 2'b00;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      m_RREADY[1] = pat[c];
      s_RVALID    = 1'b1;
      s_RPAYLOAD  = RB + RW'(idx);
      s_RLAST     = (idx == 1);
      #1;
      check("t4_rready", s_RREADY,   pat[c]);
      check("t4_rvalid", m_RVALID,   2'b10);
      check("t4_rdata",  m_RPAYLOAD, RB + RW'(idx));
      check("t4_busy",   busy,       1'b1);
      @(negedge ACLK);
      if (pat[c]) idx++;
    end
    s_RVALID = 1'b0;
    s_RLAST  = 1'b0;
    #1;
    check("t4_done", busy, 1'b0);

    // Reset asserted at the 2nd of 4 beats
    do_reset();
    m_ARVALID = 2'b01;
    m_RREADY  = 2'b11;
    @(negedge ACLK);
    @(negedge ACLK);
    m_ARVALID = 2'b00;
    s_RVALID  = 1'b1;
    s_RLAST   = 1'b0;
    @(negedge ACLK); #1;
    check("t5_beat2", m_RVALID, 2'b01);
    ARESETn = 1'b0;
    #1;
    check("t5_rvalid",  m_RVALID,  2'b00);
    check("t5_rready",  s_RREADY,  1'b0);
    check("t5_arvalid", s_ARVALID, 1'b0);
    check("t5_arready", m_ARREADY, 2'b00);
    check("t5_busy",    busy,      1'b0);
    check("t5_grant",   grant_idx, 1'b0);
    @(negedge ACLK);
    s_RVALID  = 1'b0;
    ARESETn   = 1'b1;
    m_ARVALID = 2'b10;
    @(negedge ACLK); #1;
    check("t5_re_arv",   s_ARVALID, 1'b1);
    check("t5_re_grant", grant_idx, 1'b1);
    check("t5_re_ready", m_ARREADY, 2'b10);

    // QoS: master 0 QoS=2, master 1 QoS=8
    do_reset();
    m_ARQOS   = {4'd8, 4'd2};
    m_ARVALID = 2'b11;
    @(negedge ACLK); #1;
`ifdef MQS_AXI_RD_ARB_QOS_EN
    check("t6_grant", grant_idx, 1'b1);
    check("t6_qos",   s_ARQOS,   4'd8);
`else
    check("t6_grant", grant_idx, 1'b0);
    check("t6_qos",   s_ARQOS,   4'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
